fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 54 +++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants for the instruction fetch unit.
// Widths default from `INSTMEM_ADDR_WIDTH / `INST_LENGTH; FETCH_PERF_CNT_EN adds counters.
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INST_LENGTH
`define INST_LENGTH 32
`endif

package fetch_unit_pkg;

  localparam int ADDR_W = `INSTMEM_ADDR_WIDTH;
  localparam int INST_W = `INST_LENGTH;

  // opcode field sits in the top OPC_W bits of a word
  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  typedef logic [1:0] fstate_t;
  localparam fstate_t S_IDLE   = 2'd0;
  localparam fstate_t S_FETCH  = 2'd1;
  localparam fstate_t S_DRAIN  = 2'd2;
  localparam fstate_t S_HALTED = 2'd3;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetched words and their PCs.
// Flush empties it in one cycle; head is a plain register read.
module fetch_buffer #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [AW-1:0] push_pc,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [AW-1:0] head_pc,
  output logic [1:0]    count
);

  logic [DW-1:0] data_q [2];
  logic [AW-1:0] pc_q [2];
  logic          rd_q;
  logic          wr_q;

  assign head_data = data_q[rd_q];
  assign head_pc   = pc_q[rd_q];

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      count     <= 2'd0;
    end else if (flush) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_q] <= push_data;
        pc_q[wr_q]   <= push_pc;
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer feeding decode through a 2-entry buffer.
// Optional FETCH_PERF_CNT_EN adds fetched_cnt / stall_cnt outputs.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = `INSTMEM_ADDR_WIDTH,
  parameter int INST_WIDTH = `INST_LENGTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  busy,
  output logic                  halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]           fetched_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  fstate_t               state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] tag_pc_q;
  logic                  inflight_q;
  logic [1:0]            count;
  logic                  pop;
  logic                  redir;
  logic                  ret_halt;
  logic                  push;
  logic                  issue;
  logic                  drained;
  logic [2:0]            occ;

  assign pop      = inst_valid & inst_ready;
  assign inst_valid = count != 2'd0;
  assign redir    = redirect_valid && (state_q != S_IDLE);
  assign ret_halt = inflight_q &&
                    (imem_data[INST_WIDTH-1 -: OPC_W] == OPC_HALT);
  assign push     = inflight_q && (state_q == S_FETCH) && !redir;
  // a pop this cycle frees its slot in time for the next return
  assign occ      = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue    = (state_q == S_FETCH) && !redir && !ret_halt &&
                    (occ < 3'd2);
  assign drained  = (count == 2'd0) || ((count == 2'd1) && pop);

  assign imem_addr = pc_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign halted    = state_q == S_HALTED;

  fetch_buffer #(
    .AW(ADDR_WIDTH),
    .DW(INST_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redir),
    .push     (push),
    .push_data(imem_data),
    .push_pc  (tag_pc_q),
    .pop      (pop),
    .head_data(inst_data),
    .head_pc  (inst_pc),
    .count    (count)
  );

  // state, PC and in-flight tag; redirect overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else if (redir) begin
      state_q    <= S_FETCH;
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            pc_q       <= start_pc;
            inflight_q <= 1'b0;
          end
        end
        S_FETCH: begin
          inflight_q <= issue;
          if (issue) begin
            pc_q     <= pc_q + ADDR_WIDTH'(1);
            tag_pc_q <= pc_q;
          end
          if (ret_halt) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          inflight_q <= 1'b0;
          if (drained) begin
            state_q <= S_HALTED;
          end
        end
        S_HALTED: begin
          inflight_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // saturating transfer and stall counters, cleared on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_cnt <= '0;
      stall_cnt   <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      fetched_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (pop && (fetched_cnt != 16'hFFFF)) begin
        fetched_cnt <= fetched_cnt + 16'd1;
      end
      if (inst_valid && !inst_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against
// a sequential-program reference model and a clocked memory model.
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INST_LENGTH
`define INST_LENGTH 32
`endif

module tb_fetch_unit;

  localparam int AW = `INSTMEM_ADDR_WIDTH;
  localparam int IW = `INST_LENGTH;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          busy;
  logic          halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   fetched_cnt;
  logic [15:0]   stall_cnt;
`endif

  logic [IW-1:0] mem [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_pc      (start_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .busy          (busy),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_cnt   (fetched_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  function automatic logic [IW-1:0] halt_word(input logic [IW-1:0] low);
    logic [IW-1:0] w;
    w = low;
    w[IW-1 -: 4] = 4'hF;
    return w;
  endfunction

  function automatic logic is_halt(input logic [IW-1:0] w);
    return w[IW-1 -: 4] == 4'hF;
  endfunction

  function automatic logic [IW-1:0] plain_word();
    logic [63:0] r;
    logic [IW-1:0] w;
    r = {$urandom(), $urandom()};
    w = r[IW-1:0];
    w[IW-1 -: 4] = 4'($urandom_range(0, 14));
    return w;
  endfunction

  task automatic fill_plain();
    for (int i = 0; i < DEPTH; i++) mem[i] = plain_word();
  endtask

  task automatic load_prog(output logic [IW-1:0] p [4]);
    fill_plain();
    p[0] = IW'(32'h11);
    p[1] = IW'(32'h22);
    p[2] = IW'(32'h33);
    p[3] = halt_word('0);
    for (int i = 0; i < 4; i++) mem[i] = p[i];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start_pc = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [AW-1:0] pc);
    start = 1'b1;
    start_pc = pc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 ||
        imem_addr !== '0 || inst_pc !== '0 || inst_data !== '0) begin
      n_bad++;
      $display("FAIL reset_state: v=%b b=%b h=%b a=%h pc=%h d=%h want all 0",
               inst_valid, busy, halted, imem_addr, inst_pc, inst_data);
    end
    redirect_valid = 1'b1;
    redirect_pc = AW'(8'h40);
    inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== '0) begin
        n_bad++;
        $display("FAIL idle_ignore: busy=%b v=%b a=%h want 0 0 0",
                 busy, inst_valid, imem_addr);
      end
    end
  endtask

  task automatic test_program();
    logic [IW-1:0] p [4];
    load_prog(p);
    do_reset();
    inst_ready = 1'b1;
    pulse_start('0);
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL prog_latency: inst_valid=%b want 0", inst_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== AW'(i) || inst_data !== p[i]) begin
        n_bad++;
        $display("FAIL prog_seq[%0d]: v=%b pc=%h d=%h want 1 %h %h",
                 i, inst_valid, inst_pc, inst_data, AW'(i), p[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL prog_halt: halted=%b busy=%b want 1 0", halted, busy);
    end
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL prog_after_halt: inst_valid=%b want 0", inst_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [IW-1:0] p [4];
    int idx;
    load_prog(p);
    do_reset();
    inst_ready = 1'b1;
    pulse_start('0);
    idx = 0;
    for (int cyc = 2; cyc < 20; cyc++) begin
      @(negedge clk);
      inst_ready = !(cyc >= 3 && cyc <= 6);
      if (!inst_ready) begin
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_data !== p[0] || inst_pc !== '0) begin
          n_bad++;
          $display("FAIL stall_hold c%0d: v=%b d=%h pc=%h want 1 %h 0",
                   cyc, inst_valid, inst_data, inst_pc, p[0]);
        end
      end
      if (inst_valid && inst_ready) begin
        n_cmp++;
        if (idx >= 4) begin
          n_bad++;
          $display("FAIL stall_extra: pc=%h delivered after halt", inst_pc);
        end else if (inst_pc !== AW'(idx) || inst_data !== p[idx]) begin
          n_bad++;
          $display("FAIL stall_seq[%0d]: pc=%h d=%h want %h %h",
                   idx, inst_pc, inst_data, AW'(idx), p[idx]);
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 4 || halted !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_count: got %0d words halted=%b want 4 1", idx, halted);
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (fetched_cnt !== 16'd4 || stall_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL perf_cnt: fetched=%0d stall=%0d want 4 4",
               fetched_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_redirect();
    logic [AW-1:0] sp;
    logic [AW-1:0] exp;
    int got;
    fill_plain();
    sp = AW'($urandom_range(0, 32'h30));
    do_reset();
    inst_ready = 1'b1;
    pulse_start(sp);
    @(negedge clk);
    @(negedge clk);
    inst_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== sp) begin
      n_bad++;
      $display("FAIL redir_pre: v=%b pc=%h want 1 %h", inst_valid, inst_pc, sp);
    end
    redirect_valid = 1'b1;
    redirect_pc = AW'(8'h40);
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_flush: inst_valid=%b want 0", inst_valid);
    end
    inst_ready = 1'b1;
    exp = AW'(8'h40);
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        n_cmp++;
        if (inst_pc !== exp || inst_data !== mem[exp]) begin
          n_bad++;
          $display("FAIL redir_seq: pc=%h d=%h want %h %h",
                   inst_pc, inst_data, exp, mem[exp]);
        end
        exp = exp + AW'(1);
        got++;
      end
    end
    n_cmp++;
    if (got != 3) begin
      n_bad++;
      $display("FAIL redir_timeout: got %0d words want 3", got);
    end
  endtask

  task automatic test_wrap();
    int e;
    fill_plain();
    do_reset();
    inst_ready = 1'b1;
    pulse_start(AW'(DEPTH - 2));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = (DEPTH - 2 + i) % DEPTH;
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== AW'(e) || inst_data !== mem[e]) begin
        n_bad++;
        $display("FAIL wrap[%0d]: v=%b pc=%h d=%h want 1 %h %h",
                 i, inst_valid, inst_pc, inst_data, AW'(e), mem[e]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    fill_plain();
    do_reset();
    inst_ready = 1'b0;
    pulse_start(AW'(5));
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 ||
        imem_addr !== '0 || inst_pc !== '0 || inst_data !== '0) begin
      n_bad++;
      $display("FAIL async_reset: v=%b b=%b h=%b a=%h pc=%h d=%h want all 0",
               inst_valid, busy, halted, imem_addr, inst_pc, inst_data);
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (fetched_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL async_reset_cnt: %0d %0d want 0 0", fetched_cnt, stall_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_idle: v=%b busy=%b want 0 0", inst_valid, busy);
      end
    end
    pulse_start(AW'(9));
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || inst_pc !== AW'(9) || inst_data !== mem[9]) begin
      n_bad++;
      $display("FAIL restart: seen=%b pc=%h d=%h want 1 %h %h",
               seen, inst_pc, inst_data, AW'(9), mem[9]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_pc;
    logic done;
    logic red_prev;
    logic red;
    int fcnt;
    int scnt;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 15) == 0) mem[i] = halt_word(IW'($urandom()));
        else mem[i] = plain_word();
      end
      do_reset();
      inst_ready = 1'b1;
      exp_pc = AW'($urandom());
      pulse_start(exp_pc);
      done = 1'b0;
      red_prev = 1'b0;
      fcnt = 0;
      scnt = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (done || red_prev) begin
          n_cmp++;
          if (inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd_quiet: inst_valid=%b pc=%h want 0", inst_valid, inst_pc);
          end
        end
        if (done) begin
          n_cmp++;
          if (halted !== 1'b1) begin
            n_bad++;
            $display("FAIL rnd_halted: halted=%b want 1", halted);
          end
        end
        inst_ready = $urandom_range(0, 3) != 0;
        red = $urandom_range(0, 15) == 0;
        redirect_valid = red;
        redirect_pc = AW'($urandom());
        if (inst_valid && !inst_ready && scnt < 16'hFFFF) scnt++;
        if (inst_valid && inst_ready) begin
          if (fcnt < 16'hFFFF) fcnt++;
          n_cmp++;
          if (inst_pc !== exp_pc || inst_data !== mem[exp_pc]) begin
            n_bad++;
            $display("FAIL rnd_seq: pc=%h d=%h want %h %h",
                     inst_pc, inst_data, exp_pc, mem[exp_pc]);
          end
          if (is_halt(mem[exp_pc])) done = 1'b1;
          exp_pc = exp_pc + AW'(1);
        end
        if (red) begin
          exp_pc = redirect_pc;
          done = 1'b0;
        end
        red_prev = red;
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      if (inst_valid && !inst_ready && scnt < 16'hFFFF) scnt++;
      if (inst_valid && inst_ready && fcnt < 16'hFFFF) fcnt++;
      inst_ready = 1'b0;
      @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
      n_cmp++;
      if (fetched_cnt !== 16'(fcnt) || stall_cnt !== 16'(scnt)) begin
        n_bad++;
        $display("FAIL rnd_perf: fetched=%0d stall=%0d want %0d %0d",
                 fetched_cnt, stall_cnt, fcnt, scnt);
      end
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
